// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and port ids for the dmem arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    function automatic arb_state_t lock_state(input logic port);
        return (port == PORT_DBG) ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester port of the dmem arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker, one-hot grant
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the port that was not granted last wins.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last == PORT_DBG)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares single-port dmem between core and debug ports
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_err
);

    localparam int CNT_W = $clog2(LOCK_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t              state_q, state_d;
    logic                    last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic                    lock_err_q, lock_err_d;
    logic [1:0]              rvalid_q, rvalid_d;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] lck;
    logic [1:0] rr_gnt;
    logic [1:0] gnt;
    logic       gnt_port;
    logic       any_gnt;
    logic       owner;
    logic       release_lock;

    assign req = {m1.req,  m0.req};
    assign we  = {m1.we,   m0.we};
    assign lck = {m1.lock, m0.lock};

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last_gnt_q),
        .gnt  (rr_gnt)
    );

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        lock_cnt_d   = lock_cnt_q;
        lock_err_d   = 1'b0;
        rvalid_d     = 2'b00;
        rdata_d      = rdata_q;
        gnt          = 2'b00;
        owner        = (state_q == LOCK1) ? PORT_DBG : PORT_CORE;
        release_lock = 1'b0;

        // While locked only the owner can be served.
        unique case (state_q)
            IDLE:    gnt = rr_gnt;
            LOCK0:   gnt[PORT_CORE] = req[PORT_CORE];
            LOCK1:   gnt[PORT_DBG]  = req[PORT_DBG];
            default: gnt = 2'b00;
        endcase
        if (rst) begin
            gnt = 2'b00;
        end

        gnt_port = gnt[1];
        any_gnt  = |gnt;

        if (any_gnt) begin
            last_gnt_d = gnt_port;
        end

        unique case (state_q)
            IDLE: begin
                if (any_gnt && lck[gnt_port]) begin
                    state_d    = lock_state(gnt_port);
                    lock_cnt_d = '0;
                end
            end
            LOCK0, LOCK1: begin
                release_lock = !req[owner] || (gnt[owner] && !lck[owner]);
                if (release_lock) begin
                    state_d = IDLE;
                end else if (lock_cnt_q == CNT_LAST) begin
                    // Forced release hands the next tie to the other port.
                    state_d    = IDLE;
                    lock_err_d = 1'b1;
                    last_gnt_d = owner;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < 2; i++) begin
            if (gnt[i] && !we[i]) begin
                rvalid_d[i] = 1'b1;
                rdata_d[i]  = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= PORT_DBG;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
            rvalid_q   <= 2'b00;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_gnt) begin
            mem_we    = we[gnt_port];
            mem_addr  = gnt_port ? m1.addr  : m0.addr;
            mem_wdata = gnt_port ? m1.wdata : m0.wdata;
        end
    end

    // A response still in flight when reset arrives is dropped immediately.
    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign m0.rvalid = rvalid_q[0] & ~rst;
    assign m1.rvalid = rvalid_q[1] & ~rst;
    assign m0.rdata  = rdata_q[0];
    assign m1.rdata  = rdata_q[1];
    assign lock_err  = lock_err_q & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int LOCK_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        lock_err;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if.slave),
        .m1        (m1_if.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .lock_err  (lock_err)
    );

    logic [31:0] dmem [0:255];
    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;
    end

    // Reference model: lock owner (-1 = none), cycles held, last winner.
    int          owner, held, last, last_g, obs_g;
    logic [1:0]  e_rvalid;
    logic [31:0] e_rdata [2];
    logic        e_err, obs_err;
    logic [31:0] ref_mem [0:255];
    int          n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        owner = -1; held = 0; last = 1;
        e_rvalid = 2'b00; e_rdata[0] = '0; e_rdata[1] = '0; e_err = 1'b0;
    endtask

    task automatic drive(input int p, input logic rq, input logic w, input logic lk,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (p == 0) begin
            m0_if.req = rq; m0_if.we = w; m0_if.lock = lk; m0_if.addr = ad; m0_if.wdata = wd;
        end else begin
            m1_if.req = rq; m1_if.we = w; m1_if.lock = lk; m1_if.addr = ad; m1_if.wdata = wd;
        end
    endtask

    task automatic step();
        int          g;
        logic [1:0]  r, w, l, nr;
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic        err;
        r = {m1_if.req, m0_if.req};
        w = {m1_if.we, m0_if.we};
        l = {m1_if.lock, m0_if.lock};
        a[0] = m0_if.addr;  a[1] = m1_if.addr;
        d[0] = m0_if.wdata; d[1] = m1_if.wdata;
        #3;
        g = -1;
        if (!rst) begin
            if (owner < 0) begin
                if (r[0] && r[1]) g = 1 - last;
                else if (r[0])    g = 0;
                else if (r[1])    g = 1;
            end else if (r[owner]) begin
                g = owner;
            end
        end
        obs_g   = m1_if.gnt ? 1 : (m0_if.gnt ? 0 : -1);
        obs_err = lock_err;
        chk("m0_gnt", m0_if.gnt, g == 0);
        chk("m1_gnt", m1_if.gnt, g == 1);
        chk("mem_we", mem_we, (g >= 0) ? w[g] : 1'b0);
        chk("mem_addr", mem_addr, (g >= 0) ? a[g] : 32'h0);
        chk("mem_wdata", mem_wdata, (g >= 0) ? d[g] : 32'h0);
        chk("m0_rvalid", m0_if.rvalid, rst ? 1'b0 : e_rvalid[0]);
        chk("m1_rvalid", m1_if.rvalid, rst ? 1'b0 : e_rvalid[1]);
        chk("m0_rdata", m0_if.rdata, e_rdata[0]);
        chk("m1_rdata", m1_if.rdata, e_rdata[1]);
        chk("lock_err", lock_err, rst ? 1'b0 : e_err);
        last_g = g;
        if (rst) begin
            reset_model();
        end else begin
            nr = 2'b00; err = 1'b0;
            if (g >= 0) begin
                if (w[g]) ref_mem[a[g][9:2]] = d[g];
                else begin nr[g] = 1'b1; e_rdata[g] = ref_mem[a[g][9:2]]; end
                last = g;
            end
            if (owner < 0) begin
                if (g >= 0 && l[g]) begin owner = g; held = 0; end
            end else if (!r[owner] || (g == owner && !l[owner])) begin
                owner = -1;
            end else if (held == LOCK_MAX - 1) begin
                last = owner; owner = -1; err = 1'b1;
            end else begin
                held++;
            end
            e_rvalid = nr; e_err = err;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          exp_seq [6];
        int          err_cnt;
        logic [1:0]  pend;
        n_chk = 0; n_fail = 0;
        for (int i = 0; i < 256; i++) begin dmem[i] = '0; ref_mem[i] = '0; end
        drive(0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h5555); drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_model();
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Single read
        dmem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        step();
        chk("read_gnt", obs_g, 0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("read_data", m0_if.rdata, 32'hDEADBEEF);

        // Tie right after reset alternates starting with port 0
        rst = 1'b1; step(); rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        exp_seq = '{0, 1, 0, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin step(); chk("tie_seq", obs_g, exp_seq[i]); end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Write by port 1 then read back on port 0
        drive(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678); step();
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0); step();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); step();
        chk("wr_rd_data", m0_if.rdata, 32'h12345678);

        // Locked read-modify-write holds off port 1
        drive(0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0); step();
        chk("lock_first", obs_g, 0);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'hCAFE0001);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0); step();
        chk("lock_hold", obs_g, 0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); step();
        chk("lock_after", obs_g, 1);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); step();

        // Lock timeout: port 1 never releases
        drive(1, 1'b1, 1'b0, 1'b1, 32'h50, 32'h0); step();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h60, 32'h0);
        exp_seq = '{1, 1, 1, 1, 0, 0};
        err_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("timeout_seq", obs_g, exp_seq[i]);
            if (obs_err) err_cnt++;
        end
        chk("timeout_err_cycle", obs_err, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); step();
        if (obs_err) err_cnt++;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); step();
        if (obs_err) err_cnt++;
        chk("timeout_err_count", err_cnt, 1);

        // Reset right after a read grant
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0); step();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1; step();
        chk("rst_rvalid", obs_g, -1);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h18, 32'h0); step();
        chk("rst_tie", obs_g, 0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Random traffic; a pending request is held until granted
        pend = 2'b00;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    drive(p, ($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0,
                          $urandom & 32'hFFFF_FFFC, $urandom);
                end
            end
            rst = ($urandom % 50) == 0;
            step();
            pend[0] = m0_if.req && last_g != 0;
            pend[1] = m1_if.req && last_g != 1;
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
